// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and helpers for the execute-stage ALU.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SRL) || (op == ALU_SLL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter: shift register plus down-counter.
// done flags the cycle whose shift is the last one; result is that shifted value.
module alu_shift_iter #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     abort,
  input  logic                     start,
  input  logic                     left,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         data,
  output logic                     done,
  output logic [WIDTH-1:0]         result
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] sreg;
  logic [SHW-1:0]   cnt;
  logic             left_q;

  assign result = left_q ? (sreg << 1) : (sreg >> 1);
  assign done   = (cnt == SHW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg   <= '0;
      cnt    <= '0;
      left_q <= 1'b0;
    end else if (abort) begin
      cnt <= '0;
    end else if (start) begin
      sreg   <= data;
      cnt    <= shamt;
      left_q <= left;
    end else if (cnt != '0) begin
      sreg <= result;
      cnt  <= cnt - SHW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes and a registered result.
// Define ALU_BARREL_SHIFT_EN to compute sll/srl in one cycle instead of iteratively.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_n;
  logic [WIDTH-1:0] alu_result, result_n;
  logic [WIDTH-1:0] comb_result;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             needs_iter;
  logic             shift_start;
  logic             shift_done;
  logic [WIDTH-1:0] shift_result;

  assign shamt = SrcB[SHW-1:0];

  // Unknown opcodes fall into the default arm and behave as add.
  always_comb begin
    comb_result = SrcA + SrcB;
    case (ALUControl)
      ALU_ADD: comb_result = SrcA + SrcB;
      ALU_SUB: comb_result = SrcA - SrcB;
      ALU_AND: comb_result = SrcA & SrcB;
      ALU_OR:  comb_result = SrcA | SrcB;
      ALU_XOR: comb_result = SrcA ^ SrcB;
      ALU_SLT: comb_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_BARREL_SHIFT_EN
      ALU_SRL: comb_result = SrcA >> shamt;
      ALU_SLL: comb_result = SrcA << shamt;
`else
      ALU_SRL: comb_result = SrcA;
      ALU_SLL: comb_result = SrcA;
`endif
      default: comb_result = SrcA + SrcB;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  assign needs_iter   = 1'b0;
  assign shift_done   = 1'b0;
  assign shift_result = '0;
`else
  assign needs_iter = is_shift(ALUControl) && (shamt != '0);

  alu_shift_iter #(.WIDTH(WIDTH)) u_shift (
    .clk    (clk),
    .reset  (reset),
    .abort  (flush),
    .start  (shift_start),
    .left   (ALUControl == ALU_SLL),
    .shamt  (shamt),
    .data   (SrcA),
    .done   (shift_done),
    .result (shift_result)
  );
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_IDLE:  in_ready = 1'b1;
      S_DONE:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Flush overrides everything but reset; the held result is kept, only validity drops.
  always_comb begin
    state_n     = state;
    result_n    = alu_result;
    shift_start = 1'b0;
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (needs_iter) begin
              shift_start = 1'b1;
              state_n     = S_SHIFT;
            end else begin
              result_n = comb_result;
              state_n  = S_DONE;
            end
          end else if (state == S_DONE && out_ready) begin
            state_n = S_IDLE;
          end
        end
        S_SHIFT: begin
          if (shift_done) begin
            result_n = shift_result;
            state_n  = S_DONE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      alu_result <= '0;
    end else begin
      state      <= state_n;
      alu_result <= result_n;
    end
  end

  assign out_valid = (state == S_DONE);
  assign ALUResult = alu_result;
  assign Zero      = (alu_result == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus random traffic
// checked every cycle against a transaction-level latency/result model.
module tb_alu_exec_unit;

`ifdef ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  ALUControl = 3'd0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ALUResult;
  logic        Zero;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Model: outstanding shift cycles, whether a result is on offer, and the visible result.
  int          m_pend = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_hold = '0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a >> sh;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a ^ b;
      default: return a << sh;
    endcase
  endfunction

  function automatic bit model_ready();
    return (m_pend == 0 && !m_valid) || (m_valid && out_ready);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs the DUT sees at that edge.
  always @(posedge clk) begin
    bit rdy;
    int sh;
    if (reset) begin
      m_pend = 0; m_valid = 1'b0; m_res = '0;
    end else if (flush) begin
      m_pend = 0; m_valid = 1'b0;
    end else begin
      rdy = model_ready();
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          m_valid = 1'b1;
          m_res   = m_hold;
        end
      end
      if (rdy && in_valid) begin
        sh = int'(SrcB % 32);
        if ((ALUControl == 3'd4 || ALUControl == 3'd7) && sh != 0 && !BARREL) begin
          m_pend = sh;
          m_hold = ref_result(ALUControl, SrcA, SrcB);
        end else begin
          m_valid = 1'b1;
          m_res   = ref_result(ALUControl, SrcA, SrcB);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("in_ready",  {31'd0, in_ready},  {31'd0, model_ready()});
      checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      checkOutput("ALUResult", ALUResult, m_res);
      checkOutput("Zero",      {31'd0, Zero},      {31'd0, (m_res == 32'd0)});
    end
  end

  // Presents one op and holds it until the model says it was taken.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic ordy);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b; out_ready = ordy; flush = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (model_ready()) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit idle;
    idle = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_pend == 0 && !m_valid) begin
        idle = 1'b1;
        break;
      end
    end
    if (!idle) checkOutput("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int lows;
    int pulses;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result",    ALUResult,          32'd0);
    checkOutput("reset_zero",      {31'd0, Zero},      32'd1);

    applyStimulus(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
    @(negedge clk);
    checkOutput("t1_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t1_result", ALUResult, 32'h8000_0000);
    checkOutput("t1_zero", {31'd0, Zero}, 32'd0);
    drain();

    @(posedge clk); #1;
    in_valid = 1'b1; ALUControl = 3'd1; SrcA = 32'd5; SrcB = 32'd5; out_ready = 1'b1;
    @(posedge clk); #1;
    ALUControl = 3'd5; SrcA = 32'hFFFF_FFFF; SrcB = 32'd1;
    @(negedge clk);
    checkOutput("t2_sub_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t2_sub_result", ALUResult, 32'd0);
    checkOutput("t2_sub_zero", {31'd0, Zero}, 32'd1);
    checkOutput("t2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_slt_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t2_slt_result", ALUResult, 32'd1);
    drain();

    applyStimulus(3'd7, 32'h1, 32'd31, 1'b1);
    cyc = 0; lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (!in_ready) lows++;
      if (out_valid) break;
    end
    checkOutput("t3_latency", cyc, BARREL ? 32'd1 : 32'd32);
    checkOutput("t3_busy_cycles", lows, BARREL ? 32'd0 : 32'd31);
    checkOutput("t3_result", ALUResult, 32'h8000_0000);
    drain();

    applyStimulus(3'd4, 32'h8000_0000, 32'd4, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("t4_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t4_result", ALUResult, 32'h0800_0000);
    checkOutput("t4_in_ready", {31'd0, in_ready}, 32'd0);
    drain();

    applyStimulus(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
    @(negedge clk);
    checkOutput("t5_srl0_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t5_srl0_result", ALUResult, 32'hDEAD_BEEF);
    applyStimulus(3'd7, 32'h1234_5678, 32'h20, 1'b1);
    @(negedge clk);
    checkOutput("t5_sll20_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("t5_sll20_result", ALUResult, 32'h1234_5678);
    drain();

    applyStimulus(3'd7, 32'h1, 32'd20, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; ALUControl = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("t6_flush_pulses", pulses, 32'd0);
    checkOutput("t6_flush_idle", {31'd0, in_ready}, 32'd1);

    applyStimulus(3'd7, 32'h1, 32'd20, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checkOutput("t6_reset_pulses", pulses, 32'd0);
    checkOutput("t6_reset_result", ALUResult, 32'd0);
    checkOutput("t6_reset_zero", {31'd0, Zero}, 32'd1);

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      reset      = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 39) == 0);
      in_valid   = ($urandom_range(0, 1) == 1);
      out_ready  = ($urandom_range(0, 9) < 7);
      ALUControl = 3'($urandom_range(0, 7));
      SrcA       = $urandom;
      SrcB       = $urandom;
      if ($urandom_range(0, 1) == 1) SrcB = (SrcB & 32'hFFFF_FFE0) | 32'($urandom_range(0, 6));
      if ($urandom_range(0, 7) == 0) SrcB = SrcA;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
